seg_display_driver: RTL
=======================

Name: seg_display_driver

Overview:
- Downstream display stage of the digital calculator; consumes the 15-bit binary `result` and drives a 4-digit multiplexed seven-segment display.
- A sequential shift-add-3 (double-dabble) converter turns the binary value into BCD, one iteration per clock.
- A refresh counter scans the four digits with active-low digit enables and active-low segment outputs.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays selected (1 kHz per digit at 100 MHz); benches use 4.
- VAL_W, 15, input value width; fixed by the calculator result width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- value  input  15  unsigned binary value to display; sampled only at conversion start.
- digitSelect  output  4  active-low one-hot digit enable; bit0 = units (rightmost).
- out  output  8  active-low segments; out[6:0] = g,f,e,d,c,b,a; out[7] = dp, always 1 (off).
- busy  output  1  high while a conversion is in progress.
- bcd  output  16  displayed BCD digits {thousands,hundreds,tens,units}, for debug/verification.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - digitSelect=4'b1111, out=8'hFF, busy=0, bcd=16'h0000.
  - last_value=0, overflow flag=0, scan index=0, refresh counter=0, FSM=IDLE.
- FSM states: IDLE, CONVERT, LATCH.
  - IDLE: when value != last_value, capture value into the shift register, set last_value=value, clear iteration count, go to CONVERT, busy=1.
  - CONVERT: exactly 15 cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
  - LATCH: one cycle.
    - Copy the 16-bit BCD result to the displayed register `bcd`.
    - Set overflow = (captured value > 9999); bits above 4 digits are discarded.
    - busy=0, return to IDLE.
- Latency: from a value change seen in IDLE, `bcd` updates 17 cycles later (1 capture + 15 convert + 1 latch).
- Value changes during CONVERT/LATCH are ignored. IDLE then detects the mismatch and starts a fresh conversion. The display updates only in LATCH, so digits are never mixed between two values.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index increments mod 4 (3 wraps to 0).
  - digitSelect and out are registered, updated every cycle from the current index and displayed digits, so they lag index by 1 cycle.
  - The first active select after reset is 4'b1110, one cycle after release.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - Dash = BF (g only), blank = FF.
- Overflow: every digit shows dash (BF) while the overflow flag is set.
- Reset mid-conversion aborts it. The display returns to 0 and no partial BCD is ever latched.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits (thousands, then hundreds, then tens) show FF. The units digit always shows its code; value 0 displays as "   0". Overflow dashes take precedence over blanking.
- Undefined: all four digits always show their digit code, so 15 displays as "0015".
- `bcd` content is identical in both builds.

Decomposition:
- Shared package calc_disp_pkg holds:
  - the FSM state enum;
  - NUM_DIGITS=4 and the BCD iteration count 15;
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - the digit-enable one-hot constants.
- Natural sub-module bin2bcd_seq: the FSM plus double-dabble datapath, with interface start/value in and busy/done/bcd out.
- seg_display_driver keeps change detection, the overflow flag, the scan counter and segment encoding.

Test Plan:
- Reset, REFRESH_DIV=4: while rst=0, digitSelect=1111, out=FF, busy=0. After release, digitSelect steps 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110.
- value=15: busy=1 for 16 cycles, bcd=16'h0015 at cycle 17. Units shows 92, tens F9, hundreds/thousands show C0 (FF with LEADING_ZERO_BLANK_EN).
- value=9999 gives bcd=9999 with all digits 90. Then value=10000: all digits BF. Then value=0: units C0, rest C0 (or FF when blanked).
- value=123 then 456 applied 5 cycles into the conversion: bcd goes 0123 then 0456. No intermediate mixed value, and two busy pulses.
- rst asserted 8 cycles into the conversion of 777: busy=0 and outputs go to reset values immediately. After release, with value still 777, a full conversion completes and shows 777.
- value held constant for 200 cycles: only one conversion runs, and busy stays 0 afterwards.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display stage.
// Segment codes are active-low with bit 7 as the decimal point.
package calc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_LATCH
    } conv_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_ITERS  = 15;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] DIG_SEL_0    = 4'b1110;
    localparam logic [3:0] DIG_SEL_1    = 4'b1101;
    localparam logic [3:0] DIG_SEL_2    = 4'b1011;
    localparam logic [3:0] DIG_SEL_3    = 4'b0111;
    localparam logic [3:0] DIG_SEL_NONE = 4'b1111;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 iteration per clock,
// result published on the single LATCH cycle so partial BCD is never visible.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for start; value captured on the start cycle
//   ST_CONVERT | BCD_ITERS adjust-and-shift iterations
//   ST_LATCH   | copy finished BCD to output register, pulse done
module bin2bcd_seq
    import calc_disp_pkg::*;
#(
    parameter int VAL_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam logic [3:0] ITER_LAST = 4'(BCD_ITERS - 1);

    conv_state_t      state;
    conv_state_t      state_next;
    logic [VAL_W-1:0] bin_q;
    logic [15:0]      work_q;
    logic [15:0]      work_adj;
    logic [3:0]       iter_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                busy = 1'b1;
                if (iter_q == ITER_LAST) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bits carried out of the thousands nibble are dropped; lower digits stay exact.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= '0;
            work_q <= '0;
            iter_q <= '0;
            bcd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_q  <= value;
                        work_q <= '0;
                        iter_q <= '0;
                    end
                end
                ST_CONVERT: begin
                    work_q <= {work_adj[14:0], bin_q[VAL_W-1]};
                    bin_q  <= bin_q << 1;
                    iter_q <= iter_q + 4'd1;
                end
                ST_LATCH: begin
                    bcd <= work_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment driver with change-triggered BCD conversion.
// Build option LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module seg_display_driver
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int VAL_W       = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value,
    output logic [3:0]       digitSelect,
    output logic [7:0]       out,
    output logic             busy,
    output logic [15:0]      bcd
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [VAL_W-1:0] MAX_SHOWN = VAL_W'(9999);

    logic [VAL_W-1:0] last_value;
    logic             overflow;
    logic             start;
    logic             conv_busy;
    logic             conv_done;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       scan_idx;
    logic [3:0]       digit;
    logic [7:0]       seg_next;
    logic [3:0]       sel_next;

    // last_value holds the captured operand for the whole conversion,
    // since a new start cannot happen until the converter is idle again.
    assign start = !conv_busy && (value != last_value);
    assign busy  = conv_busy;

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_value <= '0;
            overflow   <= 1'b0;
        end else begin
            if (start) begin
                last_value <= value;
            end
            if (conv_done) begin
                overflow <= (last_value > MAX_SHOWN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        digit    = bcd[{scan_idx, 2'b00} +: 4];
        seg_next = seg_encode(digit);
`ifdef LEADING_ZERO_BLANK_EN
        case (scan_idx)
            2'd3:    if (bcd[15:12] == 4'd0) seg_next = SEG_BLANK;
            2'd2:    if (bcd[15:8] == 8'd0) seg_next = SEG_BLANK;
            2'd1:    if (bcd[15:4] == 12'd0) seg_next = SEG_BLANK;
            default: begin
            end
        endcase
`endif
        if (overflow) begin
            seg_next = SEG_DASH;
        end
    end

    always_comb begin
        case (scan_idx)
            2'd0:    sel_next = DIG_SEL_0;
            2'd1:    sel_next = DIG_SEL_1;
            2'd2:    sel_next = DIG_SEL_2;
            default: sel_next = DIG_SEL_3;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digitSelect <= DIG_SEL_NONE;
            out         <= SEG_BLANK;
        end else begin
            digitSelect <= sel_next;
            out         <= seg_next;
        end
    end

endmodule
